// File: rtl/decode_stage.sv
// -----------------------------------------------------------------------------
// decode_stage
// Registered, handshaked decode stage for the MIPS subset
// LW SW J JAL JR BEQ BNE XORI ADDI ADD SUB SLT, sitting between fetch and
// execute. Each accepted instruction becomes a registered control bundle one
// cycle later. A load-use hazard against the previous LW inserts a single
// bubble bundle, and flush kills whatever bundle is currently held.
//
// State table
//   RUN    | no load outstanding, instructions pass straight through
//   SHADOW | last loaded bundle was an LW with rt!=0; load_dst_q holds its rt
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   in_valid/in_ready       fetch-side handshake
//   in_instr, in_pc         instruction word and its PC
//   flush                   drop the held bundle, accept nothing this cycle
//   out_valid/out_ready     execute-side handshake
//   out_pc ... illegal      registered control bundle
//   stall_count             saturating count of inserted bubbles
// -----------------------------------------------------------------------------
module decode_stage #(
    parameter int DATA_W      = 32,
    parameter int PC_W        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_instr,
    input  logic [PC_W-1:0]        in_pc,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        out_pc,
    output logic [2:0]             alu_op,
    output logic                   alu_src_imm,
    output logic [DATA_W-1:0]      imm,
    output logic [REG_ADDR_W-1:0]  rs,
    output logic [REG_ADDR_W-1:0]  rt,
    output logic [REG_ADDR_W-1:0]  dst_reg,
    output logic                   reg_write,
    output logic                   mem_write,
    output logic                   mem_to_reg,
    output logic                   jump,
    output logic                   jump_link,
    output logic                   jump_reg,
    output logic                   branch_eq,
    output logic                   branch_ne,
    output logic                   bubble,
    output logic                   illegal,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    typedef enum logic {RUN = 1'b0, SHADOW = 1'b1} state_t;

    typedef struct packed {
        logic [PC_W-1:0]       pc;
        logic [2:0]            alu_op;
        logic                  src_imm;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dst;
        logic                  rw;
        logic                  mw;
        logic                  m2r;
        logic                  j;
        logic                  jl;
        logic                  jr;
        logic                  beq;
        logic                  bne;
        logic                  bub;
        logic                  ill;
    } bundle_t;

    state_t                 state_q, state_d;
    logic [4:0]             load_dst_q, load_dst_d;
    logic                   valid_q, valid_d;
    bundle_t                bundle_q, bundle_d, dec;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    logic [5:0]  op, fn;
    logic [4:0]  f_rs, f_rt, f_rd;
    logic [15:0] f_imm;
    logic        uses_rs, uses_rt, hazard, stage_free;

    assign op    = in_instr[31:26];
    assign f_rs  = in_instr[25:21];
    assign f_rt  = in_instr[20:16];
    assign f_rd  = in_instr[15:11];
    assign fn    = in_instr[5:0];
    assign f_imm = in_instr[15:0];

    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        dec.rs  = REG_ADDR_W'(f_rs);
        dec.rt  = REG_ADDR_W'(f_rt);
        dec.imm = DATA_W'(signed'(f_imm));
        case (op)
            OP_LW:   begin dec.src_imm = 1'b1; dec.rw = 1'b1; dec.m2r = 1'b1; dec.dst = REG_ADDR_W'(f_rt); end
            OP_SW:   begin dec.src_imm = 1'b1; dec.mw = 1'b1; end
            OP_ADDI: begin dec.src_imm = 1'b1; dec.rw = 1'b1; dec.dst = REG_ADDR_W'(f_rt); end
            OP_XORI: begin
                dec.alu_op = 3'd2; dec.imm = DATA_W'(f_imm);
                dec.src_imm = 1'b1; dec.rw = 1'b1; dec.dst = REG_ADDR_W'(f_rt);
            end
            OP_BEQ:  begin dec.alu_op = 3'd1; dec.beq = 1'b1; end
            OP_BNE:  begin dec.alu_op = 3'd1; dec.bne = 1'b1; end
            OP_J:    dec.j = 1'b1;
            OP_JAL:  begin dec.j = 1'b1; dec.jl = 1'b1; dec.rw = 1'b1; dec.dst = REG_ADDR_W'(31); end
            OP_RTYPE: begin
                case (fn)
                    FN_JR:  begin dec.j = 1'b1; dec.jr = 1'b1; end
                    FN_ADD: begin dec.rw = 1'b1; dec.dst = REG_ADDR_W'(f_rd); end
                    FN_SUB: begin dec.alu_op = 3'd1; dec.rw = 1'b1; dec.dst = REG_ADDR_W'(f_rd); end
                    FN_SLT: begin dec.alu_op = 3'd3; dec.rw = 1'b1; dec.dst = REG_ADDR_W'(f_rd); end
                    default: dec.ill = 1'b1;
                endcase
            end
            default: dec.ill = 1'b1;
        endcase
    end

    // Jump targets overlay the rs/rt fields, so J/JAL never read registers.
    assign uses_rs    = (op != OP_J) && (op != OP_JAL);
    assign uses_rt    = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    assign hazard     = (state_q == SHADOW) &&
                        ((uses_rs && (f_rs == load_dst_q)) || (uses_rt && (f_rt == load_dst_q)));
    assign stage_free = !valid_q || out_ready;
    assign in_ready   = stage_free && !flush && !hazard;

    always_comb begin
        state_d    = state_q;
        load_dst_d = load_dst_q;
        valid_d    = valid_q;
        bundle_d   = bundle_q;
        stall_d    = stall_q;
        if (flush) begin
            valid_d = 1'b0;
            state_d = RUN;
        end else if (stage_free) begin
            if (in_valid && hazard) begin
                valid_d      = 1'b1;
                bundle_d     = '0;
                bundle_d.bub = 1'b1;
                stall_d      = (&stall_q) ? stall_q : stall_q + STALL_CNT_W'(1);
                state_d      = RUN;
            end else if (in_valid) begin
                valid_d  = 1'b1;
                bundle_d = dec;
                // A load to $0 can never create a dependency.
                if ((op == OP_LW) && (f_rt != 5'd0)) begin
                    state_d    = SHADOW;
                    load_dst_d = f_rt;
                end else begin
                    state_d = RUN;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            load_dst_q <= '0;
            valid_q    <= 1'b0;
            bundle_q   <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            load_dst_q <= load_dst_d;
            valid_q    <= valid_d;
            bundle_q   <= bundle_d;
            stall_q    <= stall_d;
        end
    end

    assign out_valid   = valid_q;
    assign out_pc      = bundle_q.pc;
    assign alu_op      = bundle_q.alu_op;
    assign alu_src_imm = bundle_q.src_imm;
    assign imm         = bundle_q.imm;
    assign rs          = bundle_q.rs;
    assign rt          = bundle_q.rt;
    assign dst_reg     = bundle_q.dst;
    assign reg_write   = bundle_q.rw;
    assign mem_write   = bundle_q.mw;
    assign mem_to_reg  = bundle_q.m2r;
    assign jump        = bundle_q.j;
    assign jump_link   = bundle_q.jl;
    assign jump_reg    = bundle_q.jr;
    assign branch_eq   = bundle_q.beq;
    assign branch_ne   = bundle_q.bne;
    assign bubble      = bundle_q.bub;
    assign illegal     = bundle_q.ill;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_decode_stage.sv
// -----------------------------------------------------------------------------
// tb_decode_stage
// Directed scenarios followed by a randomized run of decode_stage, compared
// every cycle against a behavioural model built from the instruction table
// and the hazard/flush/handshake rules. A narrow stall counter is used so
// saturation is reached during the run.
// -----------------------------------------------------------------------------
module tb_decode_stage;

    localparam int SCW  = 4;
    localparam int SMAX = 15;

    logic        clk, reset_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, imm;
    logic [2:0]  alu_op;
    logic        alu_src_imm;
    logic [4:0]  rs, rt, dst_reg;
    logic        reg_write, mem_write, mem_to_reg, jump, jump_link, jump_reg;
    logic        branch_eq, branch_ne, bubble, illegal;
    logic [SCW-1:0] stall_count;

    int errors = 0;
    int checks = 0;

    decode_stage #(.DATA_W(32), .PC_W(32), .REG_ADDR_W(5), .STALL_CNT_W(SCW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm(imm),
        .rs(rs), .rt(rt), .dst_reg(dst_reg),
        .reg_write(reg_write), .mem_write(mem_write), .mem_to_reg(mem_to_reg),
        .jump(jump), .jump_link(jump_link), .jump_reg(jump_reg),
        .branch_eq(branch_eq), .branch_ne(branch_ne),
        .bubble(bubble), .illegal(illegal), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum {K_LW, K_SW, K_ADDI, K_XORI, K_BEQ, K_BNE, K_J, K_JAL,
                  K_JR, K_ADD, K_SUB, K_SLT, K_ILL} kind_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [2:0]  alu;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rs, rt, dst;
        logic        rw, mw, m2r, j, jl, jr, beq, bne, bub, ill;
    } bun_t;

    // model state
    logic m_valid;
    bun_t m_b;
    int   m_ld;
    int   m_stall;

    function automatic kind_t classify(input logic [31:0] ins);
        case (ins[31:26])
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h08: return K_ADDI;
            6'h0E: return K_XORI;
            6'h04: return K_BEQ;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            6'h00: begin
                case (ins[5:0])
                    6'h08: return K_JR;
                    6'h20: return K_ADD;
                    6'h22: return K_SUB;
                    6'h2A: return K_SLT;
                    default: return K_ILL;
                endcase
            end
            default: return K_ILL;
        endcase
    endfunction

    function automatic bun_t expect_bundle(input logic [31:0] ins, input logic [31:0] pc);
        bun_t  b;
        kind_t k;
        k      = classify(ins);
        b      = '0;
        b.pc   = pc;
        b.rs   = ins[25:21];
        b.rt   = ins[20:16];
        b.imm  = (k == K_XORI) ? {16'h0000, ins[15:0]} : {{16{ins[15]}}, ins[15:0]};
        if (k == K_ILL) begin
            b.ill = 1'b1;
            return b;
        end
        b.alu = (k inside {K_SUB, K_BEQ, K_BNE}) ? 3'd1 :
                (k == K_XORI) ? 3'd2 : (k == K_SLT) ? 3'd3 : 3'd0;
        b.src = k inside {K_LW, K_SW, K_ADDI, K_XORI};
        b.rw  = k inside {K_LW, K_ADDI, K_XORI, K_JAL, K_ADD, K_SUB, K_SLT};
        b.mw  = (k == K_SW);
        b.m2r = (k == K_LW);
        b.j   = k inside {K_J, K_JAL, K_JR};
        b.jl  = (k == K_JAL);
        b.jr  = (k == K_JR);
        b.beq = (k == K_BEQ);
        b.bne = (k == K_BNE);
        if (k == K_JAL)                          b.dst = 5'd31;
        else if (k inside {K_ADD, K_SUB, K_SLT}) b.dst = ins[15:11];
        else if (k inside {K_LW, K_ADDI, K_XORI}) b.dst = ins[20:16];
        return b;
    endfunction

    function automatic logic reads_reg(input logic [31:0] ins, input int r);
        kind_t      k;
        logic [4:0] rr;
        k  = classify(ins);
        rr = r[4:0];
        if (k inside {K_J, K_JAL}) return 1'b0;
        if (ins[25:21] == rr) return 1'b1;
        if ((ins[31:26] == 6'h00 || k inside {K_SW, K_BEQ, K_BNE}) && ins[20:16] == rr) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bun_t observed();
        bun_t b;
        b.pc = out_pc;   b.alu = alu_op;  b.src = alu_src_imm; b.imm = imm;
        b.rs = rs;       b.rt = rt;       b.dst = dst_reg;
        b.rw = reg_write; b.mw = mem_write; b.m2r = mem_to_reg;
        b.j = jump;      b.jl = jump_link; b.jr = jump_reg;
        b.beq = branch_eq; b.bne = branch_ne; b.bub = bubble; b.ill = illegal;
        return b;
    endfunction

    task automatic check(input string tag, input logic [127:0] obsv, input logic [127:0] expv);
        checks++;
        assert (obsv === expv)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obsv, expv);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_b     = '0;
        m_ld    = -1;
        m_stall = 0;
    endtask

    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic fl, input logic ordy);
        logic free, haz, exp_rdy;
        bun_t bub_b;
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        flush     = fl;
        out_ready = ordy;
        #1;
        free    = !m_valid || ordy;
        haz     = (m_ld >= 0) && reads_reg(ins, m_ld);
        exp_rdy = free && !fl && !haz;
        check("in_ready", 128'(in_ready), 128'(exp_rdy));
        if (fl) begin
            m_valid = 1'b0;
            m_ld    = -1;
        end else if (free) begin
            if (v && haz) begin
                bub_b     = '0;
                bub_b.bub = 1'b1;
                m_valid   = 1'b1;
                m_b       = bub_b;
                if (m_stall < SMAX) m_stall++;
                m_ld      = -1;
            end else if (v) begin
                m_valid = 1'b1;
                m_b     = expect_bundle(ins, pc);
                m_ld    = (classify(ins) == K_LW && ins[20:16] != 5'd0) ? int'(ins[20:16]) : -1;
            end else begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", 128'(out_valid), 128'(m_valid));
        check("stall_count", 128'(stall_count), 128'(m_stall[SCW-1:0]));
        if (m_valid) check("bundle", 128'(observed()), 128'(m_b));
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #2;
        check({tag, " out_valid"}, 128'(out_valid), 128'(0));
        check({tag, " stall_count"}, 128'(stall_count), 128'(0));
        check({tag, " bundle"}, 128'(observed()), 128'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  a, b, d;
        logic [15:0] i16;
        int          k;
        a   = 5'($urandom_range(0, 3));
        b   = 5'($urandom_range(0, 3));
        d   = 5'($urandom_range(0, 3));
        i16 = 16'($urandom);
        k   = $urandom_range(0, 12);
        case (k)
            0:  return {6'h23, a, b, i16};
            1:  return {6'h2B, a, b, i16};
            2:  return {6'h08, a, b, i16};
            3:  return {6'h0E, a, b, i16};
            4:  return {6'h04, a, b, i16};
            5:  return {6'h05, a, b, i16};
            6:  return {6'h02, a, b, i16};
            7:  return {6'h03, a, b, i16};
            8:  return {6'h00, a, 5'd0, 5'd0, 5'd0, 6'h08};
            9:  return {6'h00, a, b, d, 5'd0, 6'h20};
            10: return {6'h00, a, b, d, 5'd0, 6'h22};
            11: return {6'h00, a, b, d, 5'd0, 6'h2A};
            default: return ($urandom_range(0, 1) == 0) ? {6'h3F, a, b, i16} : {6'h00, a, b, d, 5'd0, 6'h01};
        endcase
    endfunction

    initial begin
        logic v, fl, ordy;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        model_reset();
        #12;
        check("reset out_valid", 128'(out_valid), 128'(0));
        check("reset stall_count", 128'(stall_count), 128'(0));
        check("reset bundle", 128'(observed()), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // T1 ADD $3,$1,$2
        cycle(1'b1, 32'h00221820, 32'h0000_0100, 1'b0, 1'b1);
        check("T1 alu_op", 128'(alu_op), 128'(3'd0));
        check("T1 dst_reg", 128'(dst_reg), 128'(5'd3));
        check("T1 reg_write", 128'(reg_write), 128'(1'b1));
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

        // T2 XORI zero-extends, ADDI sign-extends
        cycle(1'b1, 32'h3884FFFF, 32'h0000_0104, 1'b0, 1'b1);
        check("T2 xori imm", 128'(imm), 128'(32'h0000FFFF));
        cycle(1'b1, 32'h2084FFFF, 32'h0000_0108, 1'b0, 1'b1);
        check("T2 addi imm", 128'(imm), 128'(32'hFFFFFFFF));

        // T3 LW $5 then ADD $6,$5,$1 -> one bubble
        cycle(1'b1, 32'h8C050000, 32'h0000_010C, 1'b0, 1'b1);
        cycle(1'b1, 32'h00A13020, 32'h0000_0110, 1'b0, 1'b1);
        check("T3 bubble", 128'(bubble), 128'(1'b1));
        check("T3 stall_count", 128'(stall_count), 128'(1));
        cycle(1'b1, 32'h00A13020, 32'h0000_0110, 1'b0, 1'b1);
        check("T3 add bubble", 128'(bubble), 128'(1'b0));
        check("T3 add dst", 128'(dst_reg), 128'(5'd6));

        // T4 LW $0 then use $0; LW $5 then J -> no bubble
        cycle(1'b1, 32'h8C000000, 32'h0000_0114, 1'b0, 1'b1);
        cycle(1'b1, 32'h00003020, 32'h0000_0118, 1'b0, 1'b1);
        check("T4 lw0 bubble", 128'(bubble), 128'(1'b0));
        cycle(1'b1, 32'h8C050000, 32'h0000_011C, 1'b0, 1'b1);
        cycle(1'b1, 32'h08A00010, 32'h0000_0120, 1'b0, 1'b1);
        check("T4 j bubble", 128'(bubble), 128'(1'b0));
        check("T4 stall_count", 128'(stall_count), 128'(1));

        // T5 hold BEQ for 3 cycles, then flush
        cycle(1'b1, 32'h10220004, 32'h0000_0124, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h00221820, 32'h0000_0128, 1'b0, 1'b0);
        check("T5 held branch_eq", 128'(branch_eq), 128'(1'b1));
        check("T5 held pc", 128'(out_pc), 128'(32'h0000_0124));
        cycle(1'b1, 32'h00221820, 32'h0000_0128, 1'b1, 1'b0);
        check("T5 flush out_valid", 128'(out_valid), 128'(1'b0));

        // T6 illegal opcode, then async reset mid-stream
        cycle(1'b1, 32'hFC000000, 32'h0000_012C, 1'b0, 1'b1);
        check("T6 illegal", 128'(illegal), 128'(1'b1));
        check("T6 reg_write", 128'(reg_write), 128'(1'b0));
        cycle(1'b1, 32'h8C050000, 32'h0000_0130, 1'b0, 1'b0);
        async_reset("T6 reset");

        // randomized run
        for (int i = 0; i < 3000; i++) begin
            v    = ($urandom_range(0, 9) < 8);
            ordy = ($urandom_range(0, 3) != 0);
            fl   = ($urandom_range(0, 19) == 0);
            cycle(v, rand_instr(), $urandom, fl, ordy);
            if (i == 1500) async_reset("mid reset");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
